// File: rtl/mem_pkg.sv
// mem_pkg -- shared definitions for the mem_responder slice.
//   state_e          : responder FSM state (IDLE, WAIT, RESP)
//   MEM_DEPTH_DEF    : default number of 32-bit words
//   MEM_LATENCY_DEF  : default accept-to-ready latency in cycles
//   CNT_W            : latency counter width (covers LATENCY up to 15)
//   addr_err()       : misaligned / out-of-range check for a byte address
package mem_pkg;

  localparam int MEM_DEPTH_DEF   = 256;
  localparam int MEM_LATENCY_DEF = 3;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // The word index is compared at full width so that addresses far
  // beyond the array never alias onto a valid word.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if -- request/response bundle between a requester and
// mem_responder.
//   req   : requester asks for a transfer (only looked at while idle)
//   wr    : 1 = write, 0 = read, captured with req
//   addr  : byte address, captured with req
//   wdata : write data, captured with req
//   busy  : responder is not idle
//   ready : one-cycle completion pulse
//   rdata : read data, meaningful with ready on a read, held otherwise
//   err   : with ready, 1 = transfer rejected
//
// Handshake: there is no back-pressure on the response. A request is taken
// at a rising edge where req=1 and busy=0; exactly LATENCY cycles later
// ready is high for one cycle with err/rdata valid. req is ignored while
// busy=1, so a requester that keeps req high simply gets the next transfer
// started in the first idle cycle.
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, wr, addr, wdata,
    input  busy, ready, rdata, err
  );

  modport slave (
    input  req, wr, addr, wdata,
    output busy, ready, rdata, err
  );
endinterface

// File: rtl/mem_array.sv
// mem_array -- word storage for mem_responder.
//   clk_i   : clock
//   rst_i   : synchronous active-high clear of every word
//   we_i    : write enable
//   waddr_i : write word index
//   wdata_i : write data
//   raddr_i : read word index (combinational read)
//   rdata_o : word at raddr_i
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = MEM_DEPTH_DEF,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Clear wins over a write in the same cycle, so a reset landing on the
  // response cycle still leaves the array all-zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// mem_responder -- fixed-latency single-outstanding memory responder.
//   clock       : single clock, rising edge
//   reset       : synchronous active-high reset
//   bus         : mem_responder_if.slave (req/wr/addr/wdata in,
//                 busy/ready/rdata/err out)
//   dbg_state_o : current FSM state, for observation only
//
// A request taken in cycle N completes with a ready pulse in cycle
// N+LATENCY. Rejected transfers (misaligned or beyond DEPTH) never touch
// storage and leave rdata unchanged.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = MEM_DEPTH_DEF,
  parameter int LATENCY = MEM_LATENCY_DEF
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus,
  output state_e          dbg_state_o
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q, wr_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             mem_we;
  logic [31:0]      mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          // Everything the transfer needs is latched here; the requester
          // may change its inputs freely afterwards.
          wr_d    = bus.wr;
          idx_d   = bus.addr[IDX_W+1:2];
          wdata_d = bus.wdata;
          err_d   = addr_err(bus.addr, DEPTH);
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end

      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end
        // Leave when the counter reaches zero at this edge: the first WAIT
        // cycle holds LATENCY-1, so RESP lands LATENCY cycles after accept.
        if (cnt_q <= CNT_ONE) begin
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (!err_q) begin
          if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem_rdata;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // rdata_d already carries the freshly read word during a good read's
  // RESP cycle and the held value at every other time.
  assign bus.busy    = (state_q != IDLE);
  assign bus.ready   = (state_q == RESP);
  assign bus.err     = (state_q == RESP) && err_q;
  assign bus.rdata   = rdata_d;
  assign dbg_state_o = state_q;

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem_array (
    .clk_i   (clock),
    .rst_i   (reset),
    .we_i    (mem_we),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- self-checking bench for mem_responder.
// u_dut0 uses the default build (DEPTH=256, LATENCY=3); u_dut1 is a
// LATENCY=1, DEPTH=16 build.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int LAT0   = 3;
  localparam int DEPTH0 = 256;
  localparam int LAT1   = 1;
  localparam int DEPTH1 = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   n_cmp  = 0;
  int   n_err  = 0;
  logic mon_en = 1'b0;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();
  state_e st0, st1;

  mem_responder #(.DEPTH(DEPTH0), .LATENCY(LAT0)) u_dut0 (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus0),
    .dbg_state_o (st0)
  );

  mem_responder #(.DEPTH(DEPTH1), .LATENCY(LAT1)) u_dut1 (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus1),
    .dbg_state_o (st1)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_mem [DEPTH0];
  logic [31:0] prev_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor for u_dut0 plus the LATENCY=1 no-WAIT watch.
  always @(negedge clock) begin
    if (mon_en) begin
      if (bus0.ready !== 1'b1) begin
        check("err_without_ready", {31'b0, bus0.err}, 32'd0);
      end else if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_ready: ready=1 at cycle %0d, expected no response", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("ready_cycle", cyc, mon_e.cyc);
        check("resp_err", {31'b0, bus0.err}, {31'b0, mon_e.err});
        check("resp_rdata", bus0.rdata, mon_e.rdata);
      end
      check("l1_never_wait", {31'b0, st1 == WAIT}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    @(negedge clock);
    for (int i = 0; i < 40 && bus0.busy !== 1'b0; i++) @(negedge clock);
    if (bus0.busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: busy=%b, expected 0 within 40 cycles", bus0.busy);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // One transfer on u_dut0: drive in an idle cycle, push the expectation,
  // then scramble the inputs while the transfer is in flight.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic eerr, input logic [31:0] erd);
    exp_t e;
    wait_idle();
    bus0.req   = 1'b1;
    bus0.wr    = wr;
    bus0.addr  = addr;
    bus0.wdata = wdata;
    e.err   = eerr;
    e.rdata = erd;
    e.cyc   = cyc + LAT0;
    exp_q.push_back(e);
    @(negedge clock);
    bus0.req   = 1'b0;
    bus0.wr    = 1'($urandom_range(0, 1));
    bus0.addr  = $urandom;
    bus0.wdata = $urandom;
    wait_drain();
  endtask

  // One transfer on the LATENCY=1 build: ready must follow the accept edge.
  task automatic issue1(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic eerr, input logic [31:0] erd);
    @(negedge clock);
    check("l1_busy_before", {31'b0, bus1.busy}, 32'd0);
    bus1.req   = 1'b1;
    bus1.wr    = wr;
    bus1.addr  = addr;
    bus1.wdata = wdata;
    @(negedge clock);
    bus1.req   = 1'b0;
    bus1.addr  = $urandom;
    bus1.wdata = $urandom;
    check("l1_ready", {31'b0, bus1.ready}, 32'd1);
    check("l1_err", {31'b0, bus1.err}, {31'b0, eerr});
    check("l1_rdata", bus1.rdata, erd);
    @(negedge clock);
    check("l1_ready_drop", {31'b0, bus1.ready}, 32'd0);
    check("l1_busy_after", {31'b0, bus1.busy}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic        a;
    int          n;
    int unsigned last;
    exp_t        e;

    bus0.req = 1'b0; bus0.wr = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    bus1.req = 1'b0; bus1.wr = 1'b0; bus1.addr = '0; bus1.wdata = '0;
    for (int i = 0; i < DEPTH0; i++) model_mem[i] = '0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 32'h0000_0400, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hA5A5_A5A5};
    vecs[7]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0000};
    vecs[8]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hCAFE_F00D};
    vecs[10] = '{1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 32'hCAFE_F00D};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0000};
    vecs[12] = '{1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0000_0000};
    vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_busy", {31'b0, bus0.busy}, 32'd0);
    check("rst_ready", {31'b0, bus0.ready}, 32'd0);
    check("rst_err", {31'b0, bus0.err}, 32'd0);
    check("rst_rdata", bus0.rdata, 32'd0);
    check("rst_state", 32'(st0), 32'(IDLE));
    reset  = 1'b0;
    mon_en = 1'b1;

    // Table-driven transfers; the model tracks accepted writes.
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata);
      if (vecs[i].wr && !vecs[i].exp_err) model_mem[vecs[i].addr[9:2]] = vecs[i].wdata;
    end

    // Full storage scan: only the three good writes may have landed.
    for (int i = 0; i < DEPTH0; i++) begin
      issue(1'b0, 32'(i * 4), 32'h0, 1'b0, model_mem[i]);
    end
    prev_rd = model_mem[DEPTH0-1];

    // req held high, alternating word 0 / word 1.
    issue(1'b1, 32'h4, 32'h1111_1111, 1'b0, prev_rd);
    model_mem[1] = 32'h1111_1111;
    a = 1'b0; n = 0; last = 0;
    bus0.wr = 1'b0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      @(negedge clock);
      bus0.req = 1'b1;
      if (bus0.busy === 1'b0) begin
        bus0.addr = a ? 32'h4 : 32'h0;
        e.err   = 1'b0;
        e.rdata = model_mem[a ? 1 : 0];
        e.cyc   = cyc + LAT0;
        exp_q.push_back(e);
        if (n > 0) check("b2b_period", cyc - last, 32'(LAT0 + 1));
        last = cyc;
        n++;
        a = ~a;
      end else begin
        bus0.addr = $urandom;
      end
    end
    @(negedge clock);
    bus0.req = 1'b0;
    check("b2b_count", 32'(n), 32'd6);
    wait_drain();

    // Reset during WAIT aborts a write to 0x8; req right after release.
    wait_idle();
    bus0.req = 1'b1; bus0.wr = 1'b1; bus0.addr = 32'h8; bus0.wdata = 32'h7777_7777;
    @(negedge clock);
    bus0.req = 1'b0;
    check("abort_in_wait", 32'(st0), 32'(WAIT));
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_busy", {31'b0, bus0.busy}, 32'd0);
    check("mid_rst_rdata", bus0.rdata, 32'd0);
    check("mid_rst_state", 32'(st0), 32'(IDLE));
    for (int i = 0; i < DEPTH0; i++) model_mem[i] = '0;
    reset = 1'b0;
    bus0.req = 1'b1; bus0.wr = 1'b0; bus0.addr = 32'h8;
    e.err = 1'b0; e.rdata = 32'h0; e.cyc = cyc + LAT0;
    exp_q.push_back(e);
    @(negedge clock);
    bus0.req = 1'b0;
    wait_drain();
    issue(1'b0, 32'h10, 32'h0, 1'b0, 32'h0);

    // LATENCY=1 build.
    issue1(1'b1, 32'h3C, 32'h0BAD_CAFE, 1'b0, 32'h0);
    issue1(1'b0, 32'h3C, 32'h0,         1'b0, 32'h0BAD_CAFE);
    issue1(1'b1, 32'h40, 32'h5555_5555, 1'b1, 32'h0BAD_CAFE);
    issue1(1'b0, 32'h0,  32'h0,         1'b0, 32'h0);
    issue1(1'b0, 32'h40, 32'h0,         1'b1, 32'h0);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH, default 256, number of 32-bit words stored.
REQ-002 Parameter: LATENCY, default 3, cycles from request acceptance to ready; legal range 1..15.
REQ-003 Port: clock  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req  input  1  requester asks for a transfer; sampled only in IDLE.
REQ-006 Port: wr  input  1  1 = write, 0 = read; captured with req.
REQ-007 Port: addr  input  32  byte address; captured with req.
REQ-008 Port: wdata  input  32  write data; captured with req.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.
REQ-010 Port: ready  output  1  one-cycle pulse marking transfer completion.
REQ-011 Port: rdata  output  32  read data; valid when ready=1 for a read.
REQ-012 Port: err  output  1  valid with ready; 1 = transfer rejected.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP.
REQ-014 In IDLE with req=1, the block SHALL capture wr/addr/wdata, load the latency counter with LATENCY-1, and go to WAIT, or to RESP directly if LATENCY=1.
REQ-015 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the cycle after the counter reaches 0.
REQ-016 Accepting req in cycle N SHALL assert ready in exactly cycle N+LATENCY.
REQ-017 In RESP, ready SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE unconditionally.
REQ-018 req SHALL be ignored in WAIT and RESP; back-to-back transfers need req high in the IDLE cycle after RESP (minimum period LATENCY+1).
REQ-019 Word index SHALL be captured addr[31:2]; addr[1:0] is ignored for indexing.
REQ-020 err SHALL be 1 if addr[1:0]!=0 (misaligned) or word index >= DEPTH (out of range).
REQ-021 An erroring transfer SHALL not modify storage, and rdata SHALL hold its previous value.
REQ-022 A valid write SHALL update storage in the RESP cycle, and rdata SHALL hold its previous value.
REQ-023 A valid read SHALL drive rdata with the stored word in the RESP cycle, and rdata SHALL hold that value until the next valid read.
REQ-024 A write followed by a read to the same address SHALL return the written data.
REQ-025 err SHALL be 0 whenever ready=0.
REQ-026 Changes on wr/addr/wdata after acceptance SHALL have no effect on the transfer in flight.

Reset
REQ-027 When reset=1 at a clock edge:
  - state SHALL go to IDLE;
  - busy, ready and err SHALL be 0;
  - rdata SHALL be 0x00000000;
  - the counter SHALL be 0;
  - all storage words SHALL be 0.
REQ-028 A reset asserted mid-transfer (WAIT or RESP) SHALL abort the transfer with no ready pulse and no storage write.
REQ-029 req high in the first cycle after reset deasserts SHALL be accepted normally.

Structure
REQ-030 Shared package mem_pkg SHALL hold the state enum (IDLE, WAIT, RESP) and the default DEPTH and LATENCY constants.
REQ-031 Storage SHALL be a sub-module mem_array with:
  - one synchronous write port;
  - one combinational read port;
  - synchronous clear on reset.
REQ-032 The FSM, counter, capture registers and error check SHALL reside in mem_responder.

Verification
REQ-033 Reset, then write 0xDEADBEEF to addr 0x10, then read 0x10 (LATENCY=3) -> ready at accept+3 both times, err=0, rdata=0xDEADBEEF on the read.
REQ-034 Read addr 0x13 (misaligned) -> ready with err=1, rdata unchanged; a subsequent read of 0x10 still returns the prior value.
REQ-035 Write to addr 0x400 with DEPTH=256 -> err=1, and a full scan of storage shows no word modified.
REQ-036 Hold req high continuously, alternating addr 0x0/0x4 -> one ready every LATENCY+1 cycles, busy low exactly one cycle between transfers.
REQ-037 Accept a write to 0x8, assert reset during WAIT -> no ready pulse, and a read of 0x8 returns 0x00000000.
REQ-038 LATENCY=1 build: req accepted in cycle N -> ready in cycle N+1, and the FSM never enters WAIT.
